// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler: shares one VGA plot port between N_CLIENTS drawers, launching
// enabled drawers in index order on each frame_tick and routing the active pixel stream.
// Optional feature macro FRAME_OVERRUN_COUNT_EN adds a saturating count of ticks seen while busy.
module frame_draw_scheduler #(
  parameter int N_CLIENTS = 4,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int C_W       = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [N_CLIENTS-1:0]     client_en,
  output logic [N_CLIENTS-1:0]     client_start,
  input  logic [N_CLIENTS-1:0]     client_finished,
  input  logic [N_CLIENTS*X_W-1:0] client_x,
  input  logic [N_CLIENTS*Y_W-1:0] client_y,
  input  logic [N_CLIENTS*C_W-1:0] client_colour,
  input  logic [N_CLIENTS-1:0]     client_plot,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [C_W-1:0]           vga_colour,
  output logic                     vga_plot,
  output logic                     busy,
  output logic                     frame_done
`ifdef FRAME_OVERRUN_COUNT_EN
  ,
  input  logic                     overrun_clear,
  output logic [7:0]               overrun_count
`endif
);

  localparam int SEL_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CLIENTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_LAUNCH,
    S_WAIT_ACK,
    S_DRAW,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [SEL_W-1:0]       sel_q;
  logic [N_CLIENTS-1:0]   mask_q;
  logic [N_CLIENTS-1:0]   start_q;
  logic                   busy_q;
  logic                   done_q;

  logic sel_last;
  logic route_en;

  assign sel_last = (sel_q == LAST_SEL);

  // Frame sequencer: walks the latched mask one slot per SCAN cycle, launches and
  // tracks one drawer at a time; start/busy/done are registered alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      mask_q  <= '0;
      start_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (frame_tick) begin
            mask_q  <= client_en;
            sel_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (mask_q[sel_q]) begin
            start_q <= N_CLIENTS'(1) << sel_q;
            state_q <= S_LAUNCH;
          end else if (sel_last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            sel_q <= sel_q + 1'b1;
          end
        end
        S_LAUNCH: begin
          state_q <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // The drawer acknowledges a start by dropping its finished flag.
          if (!client_finished[sel_q]) begin
            state_q <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (client_finished[sel_q]) begin
            if (sel_last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              sel_q   <= sel_q + 1'b1;
              state_q <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          // A tick landing here is dropped; the next frame needs a fresh tick in IDLE.
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Pixel routing is only open while the selected drawer owns the port; the DRAW cycle
  // that first sees finished=1 still routes because it carries the last pixel.
  assign route_en   = (state_q == S_WAIT_ACK) || (state_q == S_DRAW);
  assign vga_x      = client_x[sel_q*X_W +: X_W];
  assign vga_y      = client_y[sel_q*Y_W +: Y_W];
  assign vga_colour = client_colour[sel_q*C_W +: C_W];
  assign vga_plot   = client_plot[sel_q] & route_en;

  assign client_start = start_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;

`ifdef FRAME_OVERRUN_COUNT_EN
  logic [7:0] overrun_q;

  // Counts ticks that arrive mid-frame, saturating at 255; a clear beats a same-cycle overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun_q <= 8'd0;
    end else if (overrun_clear) begin
      overrun_q <= 8'd0;
    end else if (frame_tick && busy_q && (overrun_q != 8'hFF)) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign overrun_count = overrun_q;
`endif

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Bench for frame_draw_scheduler: table of whole-frame scenarios with hand-derived
// start order, routed pixel count, busy length and frame_done latency, plus reset sequences.
// Drawer models respond to start pulses; inputs change 1 time unit after the rising edge.
module tb_frame_draw_scheduler;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            frame_tick;
  logic [N-1:0]    client_en = '0;
  logic [N-1:0]    client_start;
  logic [N-1:0]    client_finished;
  logic [N*XW-1:0] client_x;
  logic [N*YW-1:0] client_y;
  logic [N*CW-1:0] client_colour;
  logic [N-1:0]    client_plot;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   vga_colour;
  logic            vga_plot;
  logic            busy;
  logic            frame_done;
`ifdef FRAME_OVERRUN_COUNT_EN
  logic            overrun_clear = 1'b0;
  logic [7:0]      overrun_count;
`endif

  frame_draw_scheduler #(.N_CLIENTS(N), .X_W(XW), .Y_W(YW), .C_W(CW)) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .client_en(client_en),
    .client_start(client_start), .client_finished(client_finished),
    .client_x(client_x), .client_y(client_y), .client_colour(client_colour),
    .client_plot(client_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .frame_done(frame_done)
`ifdef FRAME_OVERRUN_COUNT_EN
    , .overrun_clear(overrun_clear), .overrun_count(overrun_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  en;
    int          len;       // cycles the drawer holds finished low
    bit          noise;     // idle drawers (and the cycle after finishing) keep plot high
    int          inj_at;    // frame-relative cycle of an extra tick (0 = none)
    int          n_ord;     // expected number of start pulses
    logic [15:0] ord;       // expected start order, one nibble per launch, first launch highest
    int          plots;     // expected routed pixels = enabled * (len + 1)
    int          busy_cyc;  // expected busy cycles = N + enabled * (len + 2)
  } row_t;

  int checks = 0;
  int errors = 0;

  // Shared between the driver/monitor process (writer) and the main sequence (reader).
  int          cyc = 0;
  int          busy_cnt = 0, plot_cnt = 0, bad_plot = 0, bad_start = 0, done_cnt = 0;
  int          done_cyc = 0, tick_cyc = 0, tick_served = 0, ord_n = 0;
  int          ord_log [0:255];
  logic [N-1:0] seen_start;
  logic        seen_busy;
  int          ph  [N];
  int          rem [N];

  // Written only by the main sequence.
  int tick_req  = 0;
  int cfg_len   = 1;
  bit cfg_noise = 1'b0;
  int inj_at    = 0;
  bit flood     = 1'b0;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Drawer models and output monitor: sample at the falling edge, drive after the rising edge.
  initial begin : drv
    int act;
    bit inj;
    client_finished = '1;
    client_plot     = '0;
    frame_tick      = 1'b0;
    for (int i = 0; i < N; i++) begin
      ph[i]  = 0;
      rem[i] = 0;
    end
    forever begin
      @(negedge clock);
      cyc++;
      seen_start = client_start;
      seen_busy  = busy;
      if (client_start != '0) begin
        if ($countones(client_start) != 1) bad_start++;
        else for (int i = 0; i < N; i++)
          if (client_start[i] && ord_n < 256) begin
            ord_log[ord_n] = i;
            ord_n++;
          end
      end
      if (busy) busy_cnt++;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (vga_plot) begin
        plot_cnt++;
        act = -1;
        for (int i = 0; i < N; i++) if (ph[i] != 0) act = i;
        if (act < 0) bad_plot++;
        else if (vga_x != XW'(16 + act) || vga_y != YW'(32 + act) || vga_colour != CW'(1 + act))
          bad_plot++;
      end

      @(posedge clock);
      #1;
      if (tick_req != tick_served) begin
        tick_served = tick_req;
        tick_cyc    = cyc + 1;
        frame_tick  = 1'b1;
      end else begin
        inj = (inj_at != 0) && ((cyc + 1 - tick_cyc + 1) == inj_at);
        frame_tick = inj || (flood && seen_busy);
      end
      for (int i = 0; i < N; i++) begin
        if (reset) begin
          ph[i] = 0;
          client_finished[i] = 1'b1;
          client_plot[i] = 1'b0;
        end else begin
          case (ph[i])
            0: begin
              if (seen_start[i]) begin
                ph[i] = 1;
                rem[i] = cfg_len;
                client_finished[i] = 1'b0;
                client_plot[i] = 1'b1;
              end else begin
                client_plot[i] = cfg_noise;
              end
            end
            1: begin
              if (rem[i] > 1) rem[i]--;
              else begin
                ph[i] = 2;
                client_finished[i] = 1'b1;
              end
            end
            default: begin
              ph[i] = 0;
              client_plot[i] = cfg_noise;
            end
          endcase
        end
      end
    end
  end

  task automatic run_row(input row_t r, input string tag);
    int b_busy, b_plot, b_bad, b_bstart, b_done, b_ord, waited, got_ord;
    @(posedge clock);
    #2;
    client_en = r.en;
    cfg_len   = r.len;
    cfg_noise = r.noise;
    inj_at    = r.inj_at;
    b_busy = busy_cnt; b_plot = plot_cnt; b_bad = bad_plot;
    b_bstart = bad_start; b_done = done_cnt; b_ord = ord_n;
    tick_req++;
    repeat (3) @(negedge clock);
    client_en = ~r.en;  // must not disturb the frame already latched
    waited = 0;
    while (done_cnt == b_done && waited < 2000) begin
      @(negedge clock);
      waited++;
    end
    repeat (4) @(negedge clock);
    inj_at = 0;
    got_ord = 0;
    for (int k = b_ord; k < ord_n; k++) got_ord = (got_ord << 4) | ord_log[k];
    check({tag, ".n_starts"}, ord_n - b_ord, r.n_ord);
    check({tag, ".start_order"}, got_ord, int'(r.ord));
    check({tag, ".onehot_start"}, bad_start - b_bstart, 0);
    check({tag, ".plot_count"}, plot_cnt - b_plot, r.plots);
    check({tag, ".foreign_plot"}, bad_plot - b_bad, 0);
    check({tag, ".busy_cycles"}, busy_cnt - b_busy, r.busy_cyc);
    check({tag, ".done_pulses"}, done_cnt - b_done, 1);
    check({tag, ".done_latency"}, done_cyc - tick_cyc + 1, r.busy_cyc + 2);
  endtask

  initial begin : main
    row_t rows [8];
    row_t post;
    int waited;
    rows[0] = '{4'h1, 10, 1'b0, 0,  1, 16'h0000, 11, 16};
    rows[1] = '{4'hA, 3,  1'b1, 0,  2, 16'h0013, 8,  14};
    rows[2] = '{4'h0, 3,  1'b1, 0,  0, 16'h0000, 0,  4};
    rows[3] = '{4'hF, 1,  1'b0, 0,  4, 16'h0123, 8,  16};
    rows[4] = '{4'hF, 3,  1'b1, 12, 4, 16'h0123, 16, 24};  // extra tick in client 1 DRAW
    rows[5] = '{4'h2, 2,  1'b1, 10, 1, 16'h0001, 3,  8};   // extra tick in the DONE cycle
    rows[6] = '{4'h8, 2,  1'b1, 0,  1, 16'h0003, 3,  8};
    rows[7] = '{4'h5, 5,  1'b1, 0,  2, 16'h0002, 12, 18};  // trailing plot after finish
    post    = '{4'h1, 2,  1'b1, 0,  1, 16'h0000, 3,  8};
    for (int i = 0; i < N; i++) begin
      client_x[i*XW +: XW]      = XW'(16 + i);
      client_y[i*YW +: YW]      = YW'(32 + i);
      client_colour[i*CW +: CW] = CW'(1 + i);
    end

    repeat (3) @(negedge clock);
    check("reset.busy", int'(busy), 0);
    check("reset.start", int'(client_start), 0);
    check("reset.frame_done", int'(frame_done), 0);
    check("reset.vga_plot", int'(vga_plot), 0);
`ifdef FRAME_OVERRUN_COUNT_EN
    check("reset.overrun_count", int'(overrun_count), 0);
`endif
    @(posedge clock);
    #3 reset = 1'b0;

    for (int r = 0; r < 8; r++) run_row(rows[r], $sformatf("row%0d", r));

`ifdef FRAME_OVERRUN_COUNT_EN
    check("overrun.after_one", int'(overrun_count), 1);
    flood = 1'b1;
    run_row('{4'h1, 320, 1'b0, 0, 1, 16'h0000, 321, 326}, "flood");
    flood = 1'b0;
    check("overrun.saturated", int'(overrun_count), 255);
    @(posedge clock);
    #2 overrun_clear = 1'b1;
    @(posedge clock);
    #2 overrun_clear = 1'b0;
    @(negedge clock);
    check("overrun.cleared", int'(overrun_count), 0);
`endif

    // Reset while client 2 is drawing: frame-relative cycles 17..19 are its DRAW.
    @(posedge clock);
    #2;
    client_en = 4'hF;
    cfg_len   = 3;
    cfg_noise = 1'b1;
    tick_req++;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while ((tick_served != tick_req || (cyc - tick_cyc + 1) < 18) && waited < 200);
    check("midreset.pre_plot", int'(vga_plot), 1);
    check("midreset.pre_x", int'(vga_x), 18);
    #1 reset = 1'b1;
    #1;
    check("midreset.busy", int'(busy), 0);
    check("midreset.vga_plot", int'(vga_plot), 0);
    check("midreset.start", int'(client_start), 0);
    check("midreset.frame_done", int'(frame_done), 0);
    @(posedge clock);
    #3 reset = 1'b0;
    run_row(post, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
